// File: rtl/wb_regfile_stage.sv
// -----------------------------------------------------------------------------
// wb_regfile_stage
//   Writeback stage.
//   - Decodes the W-stage instruction to pick the writeback source.
//   - Commits the selected value to the 32x32 general register file (GRF).
//   - Serves two D-stage read ports. A write in the same cycle bypasses to them.
//   - Drives the W-stage forwarding bus.
//   - Keeps retirement bookkeeping (count, last PC, commit pulse).
//
// Parameters
//   DW      datapath / register width
//   CNT_W   width of the retired-instruction counter
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   w_instr               W-stage instruction word (0 = bubble)
//   w_pc, w_pc8           W-stage PC and PC+8 (link value)
//   w_alu_c               ALU result
//   w_ext_out             extender output (lui value)
//   w_dm_out              data-memory load value
//   w_memreg              destination register (0 = no write)
//   rs_addr, rt_addr      D-stage read addresses
//   rs_data, rt_data      D-stage read data (combinational, write-bypassed)
//   fwd_we/addr/data      W-stage forwarding bus
//   wr_data               selected writeback value (combinational)
//   retire_cnt            retired non-bubble instruction count (wraps)
//   last_pc               PC of the most recently retired non-bubble instruction
//   commit_pulse          high for one cycle after any GRF write
// -----------------------------------------------------------------------------
module wb_regfile_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    w_instr,
  input  logic [DW-1:0]    w_pc,
  input  logic [DW-1:0]    w_pc8,
  input  logic [DW-1:0]    w_alu_c,
  input  logic [DW-1:0]    w_ext_out,
  input  logic [DW-1:0]    w_dm_out,
  input  logic [4:0]       w_memreg,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [DW-1:0]    rs_data,
  output logic [DW-1:0]    rt_data,
  output logic             fwd_we,
  output logic [4:0]       fwd_addr,
  output logic [DW-1:0]    fwd_data,
  output logic [DW-1:0]    wr_data,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [DW-1:0]    last_pc,
  output logic             commit_pulse
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [1:0] {
    SRC_ALU,
    SRC_DM,
    SRC_PC8,
    SRC_EXT
  } wb_src_e;

  wb_src_e       src;
  logic [5:0]    op;
  logic [5:0]    fn;
  logic          we;
  logic          retire;
  logic [DW-1:0] grf [32];

  assign op     = w_instr[31:26];
  assign fn     = w_instr[5:0];
  assign we     = (w_memreg != 5'd0);
  assign retire = (w_instr != '0);

  // Writeback source decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    src = SRC_ALU;
    if (op == OP_LW) begin
      src = SRC_DM;
    end else if (op == OP_JAL || (op == OP_SPECIAL && fn == FN_JALR)) begin
      src = SRC_PC8;
    end else if (op == OP_LUI) begin
      src = SRC_EXT;
    end
  end

  always_comb begin
    wr_data = w_alu_c;
    unique case (src)
      SRC_DM:  wr_data = w_dm_out;
      SRC_PC8: wr_data = w_pc8;
      SRC_EXT: wr_data = w_ext_out;
      default: wr_data = w_alu_c;
    endcase
  end

  // Read ports. $0 is hard-wired to zero, even when a write targets it.
  // Otherwise a write in the same cycle takes priority over stored contents.
  always_comb begin
    rs_data = '0;
    if (rs_addr != 5'd0) begin
      rs_data = (we && rs_addr == w_memreg) ? wr_data : grf[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != 5'd0) begin
      rt_data = (we && rt_addr == w_memreg) ? wr_data : grf[rt_addr];
    end
  end

  assign fwd_we   = we;
  assign fwd_addr = we ? w_memreg : 5'd0;
  assign fwd_data = wr_data;

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample pre-edge values, with no dependence on process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is explicitly cleared on reset. A reset value
      // is architecturally visible here, so the entries need the reset loop
      // rather than being left as plain uninitialised storage.
      for (int i = 0; i < 32; i++) begin
        grf[i] <= '0;
      end
      retire_cnt   <= '0;
      last_pc      <= '0;
      commit_pulse <= 1'b0;
    end else begin
      if (we) begin
        grf[w_memreg] <= wr_data;
      end
      // An illegal bubble carrying a destination still writes the GRF,
      // but it is not counted as retired.
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        last_pc    <= w_pc;
      end
      commit_pulse <= we;
    end
  end

endmodule
